// File: rtl/retire_rob.sv
// In-order retire unit with a small reorder buffer: entries are allocated in
// program order, completed out of order by NUM_PORTS channels, retired one per cycle.
module retire_rob #(
    parameter  int NUM_PORTS = 2,
    parameter  int DEPTH     = 8,
    parameter  int XLEN      = 32,
    localparam int TAG_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_alloc_valid,
    input  logic [4:0]                 i_alloc_rd,
    input  logic                       i_alloc_wen,
    output logic                       o_alloc_ready,
    output logic [TAG_W-1:0]           o_alloc_tag,
    input  logic [NUM_PORTS-1:0]       i_cmp_valid,
    input  logic [NUM_PORTS*TAG_W-1:0] i_cmp_tag,
    input  logic [NUM_PORTS*XLEN-1:0]  i_cmp_data,
    input  logic                       i_flush,
    output logic                       o_wb_en,
    output logic [4:0]                 o_wb_rd,
    output logic [XLEN-1:0]            o_wb_data,
    output logic                       o_retire_valid,
    output logic [TAG_W:0]             o_count
);

    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] wen_q, wen_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];

    logic [TAG_W:0]   head_q, head_d;
    logic [TAG_W:0]   tail_q, tail_d;

    logic             wb_en_q, wb_en_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic             retire_valid_q, retire_valid_d;

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             retire_fire;
    logic [DEPTH-1:0] cmp_claimed;
    logic [TAG_W-1:0] cmp_tag;

    assign head_idx      = head_q[TAG_W-1:0];
    assign tail_idx      = tail_q[TAG_W-1:0];
    // Readiness depends only on registered pointers, so a same-cycle retire never frees a slot.
    assign full          = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign o_alloc_ready = !full;
    assign o_alloc_tag   = tail_idx;
    assign o_count       = tail_q - head_q;
    assign alloc_fire    = i_alloc_valid && o_alloc_ready;
    assign retire_fire   = valid_q[head_idx] && done_q[head_idx];

    assign o_wb_en        = wb_en_q;
    assign o_wb_rd        = wb_rd_q;
    assign o_wb_data      = wb_data_q;
    assign o_retire_valid = retire_valid_q;

    always_comb begin
        valid_d        = valid_q;
        done_d         = done_q;
        wen_d          = wen_q;
        rd_d           = rd_q;
        data_d         = data_q;
        head_d         = head_q;
        tail_d         = tail_q;
        wb_en_d        = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        retire_valid_d = 1'b0;
        cmp_claimed    = '0;
        cmp_tag        = '0;

        if (retire_fire) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + PTR_ONE;
            retire_valid_d    = 1'b1;
            wb_en_d           = wen_q[head_idx] && (rd_q[head_idx] != 5'd0);
            wb_rd_d           = rd_q[head_idx];
            wb_data_d         = data_q[head_idx];
        end

        // Ascending scan: the first (lowest) port to claim a tag wins.
        for (int p = 0; p < NUM_PORTS; p++) begin
            cmp_tag = i_cmp_tag[p*TAG_W +: TAG_W];
            if (i_cmp_valid[p] && valid_q[cmp_tag] && !done_q[cmp_tag] && !cmp_claimed[cmp_tag]) begin
                done_d[cmp_tag]      = 1'b1;
                data_d[cmp_tag]      = i_cmp_data[p*XLEN +: XLEN];
                cmp_claimed[cmp_tag] = 1'b1;
            end
        end

        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            wen_d[tail_idx]   = i_alloc_wen;
            rd_d[tail_idx]    = i_alloc_rd;
            tail_d            = tail_q + PTR_ONE;
        end

        if (i_flush) begin
            valid_d        = '0;
            done_d         = '0;
            head_d         = '0;
            tail_d         = '0;
            wb_en_d        = 1'b0;
            wb_rd_d        = wb_rd_q;
            wb_data_d      = wb_data_q;
            retire_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            done_q         <= '0;
            wen_q          <= '0;
            rd_q           <= '{default: '0};
            data_q         <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            wb_en_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            retire_valid_q <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            wen_q          <= wen_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            wb_en_q        <= wb_en_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            retire_valid_q <= retire_valid_d;
        end
    end

endmodule

// File: tb/tb_retire_rob.sv
// Directed bench for retire_rob: ordering, back-pressure, dual-port completion,
// x0 writes, flush, wrap-around and asynchronous reset.
module tb_retire_rob;

    localparam int NP    = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int TAG_W = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_alloc_valid;
    logic [4:0]           i_alloc_rd;
    logic                 i_alloc_wen;
    logic                 o_alloc_ready;
    logic [TAG_W-1:0]     o_alloc_tag;
    logic [NP-1:0]        i_cmp_valid;
    logic [NP*TAG_W-1:0]  i_cmp_tag;
    logic [NP*XLEN-1:0]   i_cmp_data;
    logic                 i_flush;
    logic                 o_wb_en;
    logic [4:0]           o_wb_rd;
    logic [XLEN-1:0]      o_wb_data;
    logic                 o_retire_valid;
    logic [TAG_W:0]       o_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    retire_rob #(.NUM_PORTS(NP), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_alloc_valid  (i_alloc_valid),
        .i_alloc_rd     (i_alloc_rd),
        .i_alloc_wen    (i_alloc_wen),
        .o_alloc_ready  (o_alloc_ready),
        .o_alloc_tag    (o_alloc_tag),
        .i_cmp_valid    (i_cmp_valid),
        .i_cmp_tag      (i_cmp_tag),
        .i_cmp_data     (i_cmp_data),
        .i_flush        (i_flush),
        .o_wb_en        (o_wb_en),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_retire_valid (o_retire_valid),
        .o_count        (o_count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        i_alloc_valid = 1'b0;
        i_alloc_rd    = 5'd0;
        i_alloc_wen   = 1'b0;
        i_cmp_valid   = '0;
        i_cmp_tag     = '0;
        i_cmp_data    = '0;
        i_flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic wen);
        idle();
        i_alloc_valid = 1'b1;
        i_alloc_rd    = rd;
        i_alloc_wen   = wen;
    endtask

    task automatic cmp(input int port, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
        i_cmp_valid[port]               = 1'b1;
        i_cmp_tag[port*TAG_W +: TAG_W]  = tag;
        i_cmp_data[port*XLEN +: XLEN]   = data;
    endtask

    task automatic do_flush();
        idle();
        i_flush = 1'b1;
        step();
        idle();
    endtask

    // {retire_valid, wb_en, wb_rd, wb_data}
    function automatic logic [38:0] wb_vec();
        return {o_retire_valid, o_wb_en, o_wb_rd, o_wb_data};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        total_cnt++;
        if (wb_vec() !== 39'd0) $display("FAIL reset_wb: got %h want 0", wb_vec());
        else pass_cnt++;
        total_cnt++;
        if ({o_count, o_alloc_ready, o_alloc_tag} !== {4'd0, 1'b1, 3'd0})
            $display("FAIL reset_state: count=%0d ready=%0b tag=%0d want 0/1/0", o_count, o_alloc_ready, o_alloc_tag);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_out_of_order();
        logic [38:0] exp [3];
        exp[0] = {1'b1, 1'b1, 5'd5, 32'hA};
        exp[1] = {1'b1, 1'b1, 5'd6, 32'hB};
        exp[2] = {1'b1, 1'b1, 5'd7, 32'hC};
        for (int i = 0; i < 3; i++) begin
            alloc(5'(5 + i), 1'b1);
            total_cnt++;
            if (o_alloc_tag !== 3'(i)) $display("FAIL ooo_tag%0d: got %0d want %0d", i, o_alloc_tag, i);
            else pass_cnt++;
            step();
        end
        idle(); cmp(0, 3'd2, 32'hC); step();
        total_cnt++;
        if (o_retire_valid !== 1'b0) $display("FAIL ooo_early_after_t2: retire=%0b want 0", o_retire_valid);
        else pass_cnt++;
        idle(); cmp(1, 3'd0, 32'hA); step();
        total_cnt++;
        if (o_retire_valid !== 1'b0) $display("FAIL ooo_early_after_t0: retire=%0b want 0", o_retire_valid);
        else pass_cnt++;
        idle(); cmp(0, 3'd1, 32'hB); step();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (wb_vec() !== exp[i]) $display("FAIL ooo_wb%0d: got %h want %h", i, wb_vec(), exp[i]);
            else pass_cnt++;
            idle(); step();
        end
        total_cnt++;
        if ({o_retire_valid, o_count} !== {1'b0, 4'd0})
            $display("FAIL ooo_drain: retire=%0b count=%0d want 0/0", o_retire_valid, o_count);
        else pass_cnt++;
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(5'(i + 1), 1'b1);
            step();
        end
        idle();
        total_cnt++;
        if ({o_count, o_alloc_ready} !== {4'd8, 1'b0})
            $display("FAIL full_state: count=%0d ready=%0b want 8/0", o_count, o_alloc_ready);
        else pass_cnt++;
        cmp(0, 3'd0, 32'h100); step();
        alloc(5'd20, 1'b1);
        total_cnt++;
        if (o_alloc_ready !== 1'b0) $display("FAIL full_ready_at_retire: ready=%0b want 0", o_alloc_ready);
        else pass_cnt++;
        step();
        idle();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd1, 32'h100}) $display("FAIL full_wb: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd1, 32'h100});
        else pass_cnt++;
        total_cnt++;
        if ({o_count, o_alloc_ready, o_alloc_tag} !== {4'd7, 1'b1, 3'd0})
            $display("FAIL full_refused: count=%0d ready=%0b tag=%0d want 7/1/0", o_count, o_alloc_ready, o_alloc_tag);
        else pass_cnt++;
        alloc(5'd21, 1'b1); step(); idle();
        total_cnt++;
        if ({o_count, o_alloc_ready} !== {4'd8, 1'b0})
            $display("FAIL full_refill: count=%0d ready=%0b want 8/0", o_count, o_alloc_ready);
        else pass_cnt++;
        do_flush();
    endtask

    task automatic test_dual_port();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            alloc(5'(10 + i), 1'b1);
            step();
        end
        idle(); cmp(0, 3'd0, 32'h50); cmp(1, 3'd1, 32'h51); step();
        idle(); step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd10, 32'h50}) $display("FAIL dual_wb0: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd10, 32'h50});
        else pass_cnt++;
        idle(); cmp(0, 3'd3, 32'h11); cmp(1, 3'd3, 32'h22); step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd11, 32'h51}) $display("FAIL dual_wb1: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd11, 32'h51});
        else pass_cnt++;
        idle(); cmp(0, 3'd2, 32'h52); step();
        total_cnt++;
        if (o_retire_valid !== 1'b0) $display("FAIL dual_gap: retire=%0b want 0", o_retire_valid);
        else pass_cnt++;
        idle(); step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd12, 32'h52}) $display("FAIL dual_wb2: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd12, 32'h52});
        else pass_cnt++;
        step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd13, 32'h11}) $display("FAIL dual_same_tag: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd13, 32'h11});
        else pass_cnt++;
        step();
    endtask

    task automatic test_x0();
        do_flush();
        alloc(5'd0, 1'b1); step();
        alloc(5'd9, 1'b0); step();
        idle(); cmp(0, 3'd0, 32'h33); cmp(1, 3'd1, 32'h44); step();
        idle(); step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b0, 5'd0, 32'h33}) $display("FAIL x0_rd0: got %h want %h", wb_vec(), {1'b1, 1'b0, 5'd0, 32'h33});
        else pass_cnt++;
        step();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b0, 5'd9, 32'h44}) $display("FAIL x0_nowen: got %h want %h", wb_vec(), {1'b1, 1'b0, 5'd9, 32'h44});
        else pass_cnt++;
        step();
    endtask

    task automatic test_flush();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            alloc(5'(i + 1), 1'b1);
            step();
        end
        idle(); cmp(0, 3'd2, 32'h62); cmp(1, 3'd3, 32'h63); step();
        alloc(5'd30, 1'b1); i_flush = 1'b1; step();
        idle();
        total_cnt++;
        if ({o_count, o_retire_valid, o_wb_en, o_alloc_tag} !== {4'd0, 1'b0, 1'b0, 3'd0})
            $display("FAIL flush_state: count=%0d retire=%0b wb_en=%0b tag=%0d want 0/0/0/0", o_count, o_retire_valid, o_wb_en, o_alloc_tag);
        else pass_cnt++;
        cmp(0, 3'd4, 32'h77); step();
        idle(); step();
        total_cnt++;
        if ({o_count, o_retire_valid} !== {4'd0, 1'b0})
            $display("FAIL flush_late_cmp: count=%0d retire=%0b want 0/0", o_count, o_retire_valid);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int k = 0;
        do_flush();
        for (int i = 0; i <= 20; i++) begin
            idle();
            if (i < 20) begin
                alloc(5'((i % 31) + 1), 1'b1);
                total_cnt++;
                if (o_alloc_tag !== 3'(i % DEPTH)) $display("FAIL wrap_tag%0d: got %0d want %0d", i, o_alloc_tag, i % DEPTH);
                else pass_cnt++;
            end
            if (i > 0) cmp(i % 2, 3'((i - 1) % DEPTH), 32'h1000 + 32'(i - 1));
            step();
            if (o_retire_valid === 1'b1) begin
                total_cnt++;
                if ({o_wb_rd, o_wb_data} !== {5'((k % 31) + 1), 32'h1000 + 32'(k)})
                    $display("FAIL wrap_wb%0d: rd=%0d data=%h want rd=%0d data=%h", k, o_wb_rd, o_wb_data, (k % 31) + 1, 32'h1000 + k);
                else pass_cnt++;
                k++;
            end
        end
        for (int d = 0; d < 4; d++) begin
            idle(); step();
            if (o_retire_valid === 1'b1) begin
                total_cnt++;
                if ({o_wb_rd, o_wb_data} !== {5'((k % 31) + 1), 32'h1000 + 32'(k)})
                    $display("FAIL wrap_wb%0d: rd=%0d data=%h want rd=%0d data=%h", k, o_wb_rd, o_wb_data, (k % 31) + 1, 32'h1000 + k);
                else pass_cnt++;
                k++;
            end
        end
        total_cnt++;
        if (k !== 20) $display("FAIL wrap_count: retired=%0d want 20", k);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_flush();
        alloc(5'd3, 1'b1); step();
        alloc(5'd4, 1'b1); cmp(0, 3'd0, 32'h99); step();
        idle(); cmp(0, 3'd1, 32'h98); step();
        idle();
        total_cnt++;
        if (wb_vec() !== {1'b1, 1'b1, 5'd3, 32'h99}) $display("FAIL areset_pre: got %h want %h", wb_vec(), {1'b1, 1'b1, 5'd3, 32'h99});
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (wb_vec() !== 39'd0) $display("FAIL areset_wb: got %h want 0", wb_vec());
        else pass_cnt++;
        total_cnt++;
        if ({o_count, o_alloc_ready, o_alloc_tag} !== {4'd0, 1'b1, 3'd0})
            $display("FAIL areset_state: count=%0d ready=%0b tag=%0d want 0/1/0", o_count, o_alloc_ready, o_alloc_tag);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        step();
        total_cnt++;
        if ({o_count, o_retire_valid} !== {4'd0, 1'b0})
            $display("FAIL areset_dropped: count=%0d retire=%0b want 0/0", o_count, o_retire_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_out_of_order();
        test_full();
        test_dual_port();
        test_x0();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
